// File: rtl/adder_vector_checker.sv
// Exhaustive stimulus/checker for an external combinational adder; compare once per vector after HOLD_CYCLES.
// Latency: busy 2^(2*WIDTH)*HOLD_CYCLES cycles after start, then done; no backpressure, start while busy is ignored.
module adder_vector_checker #(
  parameter int WIDTH       = 1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [VW-1:0] vec;
  logic [TW-1:0] timer;
  logic          compare;
  logic          last_vec;
  logic          mismatch;
  logic          restart;
  logic [WIDTH:0] expected_sum;

  // The vector register drives the adder directly, so the operands are glitch-free flop outputs.
  assign dut_a        = vec[VW-1:WIDTH];
  assign dut_b        = vec[WIDTH-1:0];
  assign expected_sum = {1'b0, dut_a} + {1'b0, dut_b};
  assign compare      = (state == DRIVE) && (timer == TW'(HOLD_CYCLES - 1));
  assign last_vec     = &vec;
  assign mismatch     = ({dut_c, dut_s} != expected_sum);
  assign restart      = start && (state != DRIVE);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (compare && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_nxt = DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= '0;
      timer     <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        vec       <= '0;
        timer     <= '0;
        err_count <= '0;
        fail_a    <= '0;
        fail_b    <= '0;
      end else if (state == DRIVE) begin
        if (compare) begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_a <= dut_a;
              fail_b <= dut_b;
            end
          end
          // On the last vector vec and timer freeze so the adder keeps seeing it in DONE.
          if (!last_vec) begin
            vec   <= vec + 1'b1;
            timer <= '0;
          end
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_vector_checker.sv
// Drives two checker instances (1-bit/hold 4 and 2-bit/hold 1) against a fault-injectable adder model
// and compares their verdicts with an exhaustive enumeration of the faulty adder.
module tb_adder_vector_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;

  logic [0:0] dut_a1, dut_b1, dut_s1, fail_a1, fail_b1;
  logic       dut_c1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] dut_a2, dut_b2, dut_s2, fail_a2, fail_b2;
  logic       dut_c2, busy2, done2, pass2;
  logic [4:0] err2;

  int total = 0;
  int bad   = 0;
  int mode1 = 0;
  int mode2 = 0;
  int bad_vec = 0;
  int bad_mask = 1;
  int r1, r2;

  always #5 clk = ~clk;

  adder_vector_checker #(.WIDTH(1), .HOLD_CYCLES(4)) u_w1 (
    .clk(clk), .reset(reset), .start(start1),
    .dut_a(dut_a1), .dut_b(dut_b1), .dut_s(dut_s1), .dut_c(dut_c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fail_a1), .fail_b(fail_b1)
  );

  adder_vector_checker #(.WIDTH(2), .HOLD_CYCLES(1)) u_w2 (
    .clk(clk), .reset(reset), .start(start2),
    .dut_a(dut_a2), .dut_b(dut_b2), .dut_s(dut_s2), .dut_c(dut_c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fail_a2), .fail_b(fail_b2)
  );

  // Adder under test: 0 ideal, 1 carry stuck at 0, 2 sum bits inverted, 3 one vector corrupted by a mask.
  function automatic int fadd(input int a, input int b, input int w, input int mode,
                              input int bvec, input int bmask);
    int r;
    r = a + b;
    case (mode)
      1: r = r & ~(1 << w);
      2: r = r ^ ((1 << w) - 1);
      3: if (((a << w) | b) == bvec) r = r ^ bmask;
      default: ;
    endcase
    return r & ((2 << w) - 1);
  endfunction

  always_comb begin
    r1 = fadd(int'(dut_a1), int'(dut_b1), 1, mode1, bad_vec, bad_mask);
    dut_s1 = r1[0:0];
    dut_c1 = r1[1];
    r2 = fadd(int'(dut_a2), int'(dut_b2), 2, mode2, bad_vec, bad_mask);
    dut_s2 = r2[1:0];
    dut_c2 = r2[2];
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int busy_v(input int inst);
    return (inst == 1) ? int'(busy1) : int'(busy2);
  endfunction

  function automatic int vec_v(input int inst);
    return (inst == 1) ? int'({dut_a1, dut_b1}) : int'({dut_a2, dut_b2});
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 1) start1 = v;
    else start2 = v;
  endtask

  // Pulses start, then walks the busy window checking the applied vector sequence.
  task automatic run(input int inst, input int extra_start_at, input int reset_at,
                     output int busy_n, output bit seq_ok);
    int hold;
    hold = (inst == 1) ? 4 : 1;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    busy_n = 0;
    seq_ok = 1'b1;
    while (busy_v(inst) == 1 && busy_n < 200) begin
      if (vec_v(inst) != busy_n / hold) seq_ok = 1'b0;
      busy_n++;
      set_start(inst, busy_n == extra_start_at);
      if (busy_n == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_start(inst, 1'b0);
        return;
      end
      @(negedge clk);
    end
    set_start(inst, 1'b0);
  endtask

  task automatic model(input int w, input int mode, output int errs, output int fa, output int fb);
    errs = 0;
    fa = 0;
    fb = 0;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      int a, b;
      a = v >> w;
      b = v & ((1 << w) - 1);
      if (fadd(a, b, w, mode, bad_vec, bad_mask) != a + b) begin
        if (errs == 0) begin
          fa = a;
          fb = b;
        end
        errs++;
      end
    end
  endtask

  task automatic full_run(input int inst, input int extra_start_at, input string tag);
    int n, errs, fa, fb, w;
    bit ok;
    w = (inst == 1) ? 1 : 2;
    model(w, (inst == 1) ? mode1 : mode2, errs, fa, fb);
    run(inst, extra_start_at, -1, n, ok);
    check({tag, " busy_cycles"}, n, 16);
    check({tag, " vector_seq"}, int'(ok), 1);
    if (inst == 1) begin
      check({tag, " done"}, int'(done1), 1);
      check({tag, " pass"}, int'(pass1), int'(errs == 0));
      check({tag, " err_count"}, int'(err1), errs);
      check({tag, " fail_ab"}, int'({fail_a1, fail_b1}), (fa << 1) | fb);
    end else begin
      check({tag, " done"}, int'(done2), 1);
      check({tag, " pass"}, int'(pass2), int'(errs == 0));
      check({tag, " err_count"}, int'(err2), errs);
      check({tag, " fail_ab"}, int'({fail_a2, fail_b2}), (fa << 2) | fb);
    end
  endtask

  initial begin
    int n;
    bit ok;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst busy", int'(busy1) + int'(busy2), 0);
    check("rst done_pass", int'({done1, pass1, done2, pass2}), 0);
    check("rst err", int'(err1) + int'(err2), 0);
    check("rst outputs", int'({dut_a1, dut_b1, fail_a1, fail_b1, dut_a2, dut_b2, fail_a2, fail_b2}), 0);

    mode1 = 0; full_run(1, -1, "w1 ideal");
    mode1 = 1; full_run(1, -1, "w1 carry0");
    check("w1 carry0 const", int'({err1, fail_a1, fail_b1}), (1 << 2) | 3);
    mode1 = 2; full_run(1, -1, "w1 suminv");
    check("w1 suminv const", int'(err1), 4);

    run(1, -1, 6, n, ok);
    check("midreset busy_done", int'({busy1, done1}), 0);
    check("midreset err", int'(err1), 0);
    check("midreset dut_ab", int'({dut_a1, dut_b1}), 0);
    mode1 = 0; full_run(1, -1, "w1 after_reset");

    mode1 = 2; full_run(1, 3, "w1 start_while_busy");
    mode1 = 0; full_run(1, -1, "w1 restart_from_done");

    mode2 = 0; full_run(2, -1, "w2 ideal");
    mode2 = 1; full_run(2, -1, "w2 carry0");
    check("w2 carry0 const", int'({err2, fail_a2, fail_b2}), (6 << 4) | (1 << 2) | 3);

    for (int i = 0; i < 8; i++) begin
      int inst;
      inst = $urandom_range(1, 2);
      bad_vec = $urandom_range(0, (inst == 1) ? 3 : 15);
      bad_mask = $urandom_range(1, (inst == 1) ? 3 : 7);
      if (inst == 1) mode1 = $urandom_range(0, 3);
      else mode2 = $urandom_range(0, 3);
      full_run(inst, $urandom_range(0, 15), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_vector_checker.md
Name: adder_vector_checker

Overview:
- Synthesizable stimulus generator and response checker for an external combinational adder DUT (half adder at WIDTH=1, ripple adders at larger WIDTH).
- Applies every {a,b} operand combination, waits a settle interval, and compares the DUT's {carry,sum} against a+b.
- Sits beside the adder on the board: its drive outputs go to the adder inputs, and the adder outputs return to its check inputs.
- Reports pass/fail, the error count and the first failing vector for LEDs/7-seg.

Parameters:
- WIDTH, 1, operand width of a and b; the DUT sum is WIDTH bits plus 1 carry bit.
- HOLD_CYCLES, 4, cycles each vector is held before the next is applied; minimum 1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high; all state clears on the clk edge where reset=1.
- start  input  1  one-cycle request to begin a run; sampled on clk.
- dut_a  output  WIDTH  operand a driven to the DUT.
- dut_b  output  WIDTH  operand b driven to the DUT.
- dut_s  input  WIDTH  DUT sum.
- dut_c  input  1  DUT carry-out.
- busy  output  1  high while vectors are being applied.
- done  output  1  high while in DONE.
- pass  output  1  high in DONE when err_count==0; 0 otherwise.
- err_count  output  2*WIDTH+1  number of mismatching vectors in the current/last run.
- fail_a  output  WIDTH  a of the first mismatching vector; 0 if none.
- fail_b  output  WIDTH  b of the first mismatching vector; 0 if none.

Behaviour:
- Reset values:
  - State=IDLE.
  - dut_a=dut_b=0; busy=done=pass=0; err_count=0; fail_a=fail_b=0.
  - Vector counter vec (2*WIDTH bits)=0; hold timer=0.
- Vector mapping: dut_a=vec[2W-1:W], dut_b=vec[W-1:0]. Order is vec=0..2^(2W)-1; for WIDTH=1 this gives ab=00,01,10,11.
- States:
  - IDLE: outputs at reset values. start=1 -> DRIVE next cycle with vec=0, timer=0; counters and fail capture cleared on that same edge.
  - DRIVE: busy=1; dut_a/dut_b are registered from vec. Timer increments each cycle. On the cycle where timer==HOLD_CYCLES-1, the checker compares {dut_c,dut_s} against the (WIDTH+1)-bit sum dut_a+dut_b, computed with no truncation.
    - On mismatch, err_count increments. If this is the first mismatch (err_count==0 before the increment), fail_a/fail_b capture the current vector.
    - On that same compare cycle, if vec is the last vector -> DONE. Otherwise vec increments and timer returns to 0.
  - DONE: busy=0, done=1, pass=(err_count==0). err_count, fail_a and fail_b hold; dut_a/dut_b hold the last vector. start=1 -> restart exactly as from IDLE (clears results).
- Latency:
  - busy rises on the edge after start is sampled.
  - busy is high for exactly 2^(2W)*HOLD_CYCLES cycles.
  - done rises on the following edge.
- Boundary conditions:
  - start while busy is ignored; the run is not restarted or extended.
  - reset mid-run forces IDLE and the reset values on the next edge; reset has priority over start.
  - HOLD_CYCLES=1: compare happens every cycle, one vector per cycle.
  - err_count width holds the maximum 2^(2W) without wrap; no saturation logic is needed.
  - DUT inputs are sampled only on compare cycles. Glitches during other hold cycles are not checked.

Test Plan:
- WIDTH=1, HOLD=4, ideal half adder, start pulse -> busy high 16 cycles; dut_a/dut_b step 00,01,10,11 every 4 cycles; then done=1, pass=1, err_count=0, fail_a=fail_b=0.
- WIDTH=1, HOLD=4, carry stuck at 0 -> only ab=11 fails: err_count=1, fail_a=1, fail_b=1, pass=0.
- WIDTH=1, HOLD=4, sum inverted -> all 4 vectors fail: err_count=4, first failure fail_a=0, fail_b=0, pass=0.
- Reset asserted on cycle 6 of a run -> next edge: busy=0, done=0, err_count=0, dut_a=dut_b=0. Then start -> full 16-cycle run completes normally.
- start pulsed again at cycle 3 of a run -> ignored; done still rises after 16 busy cycles. start in DONE -> err_count cleared, new run of 16 cycles.
- WIDTH=2, HOLD=1, ideal 2-bit adder -> 16 busy cycles; vector a=3, b=3 expects {c,s}=3'b110; pass=1. Forcing dut_c=0 -> err_count=6 (a+b>=4 cases), fail_a=1, fail_b=3.
